// File: rtl/spart_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : spart_result_unloader
//  Purpose  : Streams crypto results (hash / encrypt / decrypt) and a final
//             HALT marker to the SPART transmit path as framed 16-bit words.
//             A frame is a header {tag, length} followed by the result words,
//             most-significant word first.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             hash/enc/dec_result, _valid - result sources (held until ack)
//             cpu_halted                  - level, requests the HALT frame
//             tx_ready                    - downstream accepts a word
//             data_out, wr_en, w_addr     - outgoing word, valid, byte address
//             hash/enc/dec_ack            - one-cycle capture pulses
//             busy, done                  - frame in progress / HALT sent
//  Revision : 1.0  initial release
// ============================================================================
module spart_result_unloader (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [511:0] hash_result,
   input  logic         hash_valid,
   input  logic [127:0] enc_result,
   input  logic         enc_valid,
   input  logic [127:0] dec_result,
   input  logic         dec_valid,
   input  logic         cpu_halted,
   input  logic         tx_ready,
   output logic [15:0]  data_out,
   output logic         wr_en,
   output logic [15:0]  w_addr,
   output logic         hash_ack,
   output logic         enc_ack,
   output logic         dec_ack,
   output logic         busy,
   output logic         done
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_HDR      = 3'd1;
   localparam logic [2:0] S_PAYLOAD  = 3'd2;
   localparam logic [2:0] S_HALT_HDR = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [1:0] K_HASH = 2'd0;
   localparam logic [1:0] K_ENC  = 2'd1;
   localparam logic [1:0] K_DEC  = 2'd2;

   localparam logic [4:0] TAG_HASH = 5'b11100;
   localparam logic [4:0] TAG_ENCR = 5'b11101;
   localparam logic [4:0] TAG_DECR = 5'b11110;
   localparam logic [4:0] TAG_HALT = 5'b11111;

   logic [2:0]   state_q, state_d;
   logic [1:0]   kind_q, kind_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [511:0] snap_q, snap_d;
   logic [15:0]  addr_q, addr_d;
   logic         hash_ack_q, hash_ack_d;
   logic         enc_ack_q, enc_ack_d;
   logic         dec_ack_q, dec_ack_d;

   logic         xfer;
   logic [5:0]   last_idx;
   logic [4:0]   word_idx;
   logic [15:0]  payload_word;

   // A word moves only when it is presented and the sink accepts it.
   assign xfer     = wr_en & tx_ready;
   assign last_idx = (kind_q == K_HASH) ? 6'd31 : 6'd7;

   // Results are captured left-aligned in the snapshot, so payload word k is
   // always snapshot word (31 - k) regardless of the result width.
   assign word_idx     = 5'd31 - cnt_q[4:0];
   assign payload_word = snap_q[{word_idx, 4'b0000} +: 16];

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         kind_q     <= K_HASH;
         cnt_q      <= 6'd0;
         snap_q     <= 512'd0;
         addr_q     <= 16'd0;
         hash_ack_q <= 1'b0;
         enc_ack_q  <= 1'b0;
         dec_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         cnt_q      <= cnt_d;
         snap_q     <= snap_d;
         addr_q     <= addr_d;
         hash_ack_q <= hash_ack_d;
         enc_ack_q  <= enc_ack_d;
         dec_ack_q  <= dec_ack_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      cnt_d      = cnt_q;
      snap_d     = snap_q;
      addr_d     = xfer ? (addr_q + 16'd2) : addr_q;
      hash_ack_d = 1'b0;
      enc_ack_d  = 1'b0;
      dec_ack_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Fixed priority; pending results always beat the HALT frame.
            if (hash_valid) begin
               snap_d     = hash_result;
               kind_d     = K_HASH;
               hash_ack_d = 1'b1;
               state_d    = S_HDR;
            end else if (enc_valid) begin
               snap_d    = {enc_result, 384'd0};
               kind_d    = K_ENC;
               enc_ack_d = 1'b1;
               state_d   = S_HDR;
            end else if (dec_valid) begin
               snap_d    = {dec_result, 384'd0};
               kind_d    = K_DEC;
               dec_ack_d = 1'b1;
               state_d   = S_HDR;
            end else if (cpu_halted) begin
               state_d = S_HALT_HDR;
            end
         end
         S_HDR: begin
            if (xfer) begin
               state_d = S_PAYLOAD;
               cnt_d   = 6'd0;
            end
         end
         S_PAYLOAD: begin
            if (xfer) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == last_idx) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HALT_HDR: begin
            if (xfer) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      data_out = 16'd0;
      wr_en    = 1'b0;
      case (state_q)
         S_HDR: begin
            wr_en = 1'b1;
            case (kind_q)
               K_HASH:  data_out = {TAG_HASH, 11'd32};
               K_ENC:   data_out = {TAG_ENCR, 11'd8};
               default: data_out = {TAG_DECR, 11'd8};
            endcase
         end
         S_PAYLOAD: begin
            wr_en    = 1'b1;
            data_out = payload_word;
         end
         S_HALT_HDR: begin
            wr_en    = 1'b1;
            data_out = {TAG_HALT, 11'd0};
         end
         default: begin
            wr_en    = 1'b0;
            data_out = 16'd0;
         end
      endcase
   end

   assign busy     = (state_q == S_HDR) || (state_q == S_PAYLOAD) || (state_q == S_HALT_HDR);
   assign done     = (state_q == S_DONE);
   assign w_addr   = addr_q;
   assign hash_ack = hash_ack_q;
   assign enc_ack  = enc_ack_q;
   assign dec_ack  = dec_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_result_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_result_unloader
//  Purpose  : Scoreboard bench for spart_result_unloader. Stimulus pushes the
//             expected word stream (data + byte address) per frame; a monitor
//             pops and compares on every accepted word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spart_result_unloader;

   logic         clk;
   logic         rst_n;
   logic [511:0] hash_result;
   logic         hash_valid;
   logic [127:0] enc_result;
   logic         enc_valid;
   logic [127:0] dec_result;
   logic         dec_valid;
   logic         cpu_halted;
   logic         tx_ready;
   logic [15:0]  data_out;
   logic         wr_en;
   logic [15:0]  w_addr;
   logic         hash_ack;
   logic         enc_ack;
   logic         dec_ack;
   logic         busy;
   logic         done;

   spart_result_unloader dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hash_result (hash_result),
      .hash_valid  (hash_valid),
      .enc_result  (enc_result),
      .enc_valid   (enc_valid),
      .dec_result  (dec_result),
      .dec_valid   (dec_valid),
      .cpu_halted  (cpu_halted),
      .tx_ready    (tx_ready),
      .data_out    (data_out),
      .wr_en       (wr_en),
      .w_addr      (w_addr),
      .hash_ack    (hash_ack),
      .enc_ack     (enc_ack),
      .dec_ack     (dec_ack),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      logic [15:0] a;
   } exp_t;

   exp_t        exp_q[$];
   int          pop_cyc[$];
   logic [15:0] pop_addr[$];
   logic [15:0] model_addr = 16'd0;
   int          errors = 0;
   int          checks = 0;
   int          pops = 0;
   int          exp_acks = 0;
   int          got_acks = 0;
   bit          rand_ready = 1'b0;
   bit          auto_drop = 1'b1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // ------------------------------------------------ reference model (frames)
   task automatic push_word(input logic [15:0] d);
      exp_q.push_back('{d: d, a: model_addr});
      model_addr = model_addr + 16'd2;
   endtask

   // kind: 0 hash, 1 enc, 2 dec, 3 halt
   task automatic push_frame(input int kind, input logic [511:0] h, input logic [127:0] r);
      case (kind)
         0: begin
            push_word({5'b11100, 11'd32});
            for (int k = 0; k < 32; k++) push_word(h[511 - 16*k -: 16]);
         end
         1, 2: begin
            push_word({(kind == 1) ? 5'b11101 : 5'b11110, 11'd8});
            for (int k = 0; k < 8; k++) push_word(r[127 - 16*k -: 16]);
         end
         default: push_word({5'b11111, 11'd0});
      endcase
   endtask

   // --------------------------------------------------------------- monitor
   task automatic monitor();
      bit          stall = 1'b0;
      bit          prev_ack = 1'b0;
      logic [15:0] stall_d = 16'd0;
      logic [15:0] stall_a = 16'd0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall    = 1'b0;
            prev_ack = 1'b0;
            continue;
         end
         got_acks += int'(hash_ack) + int'(enc_ack) + int'(dec_ack);
         if (hash_ack || enc_ack || dec_ack) begin
            check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
            check("ack_one_hot", int'(hash_ack) + int'(enc_ack) + int'(dec_ack), 32'd1);
         end
         prev_ack = hash_ack | enc_ack | dec_ack;
         if (stall) begin
            check("hold_wr_en", {31'd0, wr_en}, 32'd1);
            check("hold_data", {16'd0, data_out}, {16'd0, stall_d});
            check("hold_addr", {16'd0, w_addr}, {16'd0, stall_a});
         end
         if (wr_en && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data=%h addr=%h, required no word", data_out, w_addr);
            end else begin
               e = exp_q.pop_front();
               check("word_data", {16'd0, data_out}, {16'd0, e.d});
               check("word_addr", {16'd0, w_addr}, {16'd0, e.a});
               pop_cyc.push_back(cyc);
               pop_addr.push_back(w_addr);
               pops++;
            end
         end
         stall   = wr_en && !tx_ready;
         stall_d = data_out;
         stall_a = w_addr;
      end
   endtask

   // ------------------------------------------------------- stimulus helpers
   // One clock: sources drop valid after seeing their ack, then tx_ready is
   // re-driven just after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (auto_drop) begin
         if (hash_ack) hash_valid = 1'b0;
         if (enc_ack)  enc_valid  = 1'b0;
         if (dec_ack)  dec_valid  = 1'b0;
      end
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
   endtask

   task automatic rand512(output logic [511:0] v);
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
   endtask

   task automatic rand128(output logic [127:0] v);
      for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom();
   endtask

   task automatic issue_group(input bit h, input bit e, input bit d);
      if (h) begin rand512(hash_result); push_frame(0, hash_result, 128'd0); end
      if (e) begin rand128(enc_result);  push_frame(1, 512'd0, enc_result);  end
      if (d) begin rand128(dec_result);  push_frame(2, 512'd0, dec_result);  end
      exp_acks += int'(h) + int'(e) + int'(d);
      if (h) hash_valid = 1'b1;
      if (e) enc_valid  = 1'b1;
      if (d) dec_valid  = 1'b1;
   endtask

   // Wait until all sources are acked (and, if drain, all expected words seen).
   task automatic wait_idle(input bit drain, input int budget, input string nm);
      int n = 0;
      while ((hash_valid || enc_valid || dec_valid || (drain && exp_q.size() != 0)) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d words outstanding, required 0", nm, exp_q.size());
      end
   endtask

   // ------------------------------------------------------------------- main
   initial begin
      int c;
      int p0;
      int r;
      int na;
      int nb;
      int wr_seen;
      int ack_seen;
      logic [15:0] start;

      rst_n       = 1'b0;
      hash_result = '0;
      hash_valid  = 1'b0;
      enc_result  = '0;
      enc_valid   = 1'b0;
      dec_result  = '0;
      dec_valid   = 1'b0;
      cpu_halted  = 1'b0;
      tx_ready    = 1'b1;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_w_addr", {16'd0, w_addr}, 32'd0);
      check("rst_data_out", {16'd0, data_out}, 32'd0);
      check("rst_acks", {29'd0, hash_ack, enc_ack, dec_ack}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Directed encryption frame, tx_ready held high: 9 words back to back
      enc_result = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      push_frame(1, 512'd0, enc_result);
      exp_acks++;
      pop_cyc.delete();
      c = cyc;
      enc_valid = 1'b1;
      wait_idle(1'b1, 200, "enc_directed");
      check("enc_word_count", pop_cyc.size(), 32'd9);
      if (pop_cyc.size() == 9) begin
         check("enc_first_latency", pop_cyc[0], c + 1);
         check("enc_no_bubble", pop_cyc[8] - pop_cyc[0], 32'd8);
      end

      // Simultaneous hash + dec: hash first, addresses continuous
      start = model_addr;
      issue_group(1'b1, 1'b0, 1'b1);
      wait_idle(1'b1, 500, "hash_dec");
      tick();
      check("hash_dec_end_addr", {16'd0, w_addr}, {16'd0, 16'(start + 16'h0054)});

      // Random groups with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bit h, e, d;
         h = 1'($urandom_range(0, 1));
         e = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         if (!(h || e || d)) e = 1'b1;
         issue_group(h, e, d);
         wait_idle(1'b0, 2000, "random_group");
      end
      wait_idle(1'b1, 2000, "random_drain");

      // Reset in the middle of a hash frame, source keeps hash_valid high
      rand_ready = 1'b0;
      auto_drop  = 1'b0;
      issue_group(1'b1, 1'b0, 1'b0);
      p0 = pops;
      c  = 0;
      while (pops < p0 + 6 && c < 200) begin tick(); c++; end
      check("midreset_progress", pops - p0, 32'd6);
      rst_n = 1'b0;
      #1;
      check("midreset_wr_en", {31'd0, wr_en}, 32'd0);
      check("midreset_w_addr", {16'd0, w_addr}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      model_addr = 16'd0;
      push_frame(0, hash_result, 128'd0);
      exp_acks++;
      tick();
      rst_n = 1'b1;
      auto_drop = 1'b1;
      wait_idle(1'b1, 500, "midreset_restart");

      // Fill the address space up to 16'hFFFC, then one enc frame across the wrap
      r  = (32766 - int'(model_addr) / 2) % 32768;
      na = -1;
      nb = 0;
      for (int a = r / 33; a >= 0; a--) begin
         if ((r - 33 * a) % 9 == 0) begin
            na = a;
            nb = (r - 33 * a) / 9;
            break;
         end
      end
      check("wrap_fill_solvable", {31'd0, na >= 0}, 32'd1);
      for (int i = 0; i < na; i++) begin
         issue_group(1'b1, 1'b0, 1'b0);
         wait_idle(1'b0, 200, "fill_hash");
      end
      for (int i = 0; i < nb; i++) begin
         issue_group(1'b0, 1'b1, 1'b0);
         wait_idle(1'b0, 200, "fill_enc");
      end
      wait_idle(1'b1, 500, "fill_drain");
      pop_addr.delete();
      issue_group(1'b0, 1'b1, 1'b0);
      wait_idle(1'b1, 200, "wrap_enc");
      check("wrap_count", pop_addr.size(), 32'd9);
      if (pop_addr.size() == 9) begin
         check("wrap_addr0", {16'd0, pop_addr[0]}, 32'h0000_FFFC);
         check("wrap_addr1", {16'd0, pop_addr[1]}, 32'h0000_FFFE);
         check("wrap_addr2", {16'd0, pop_addr[2]}, 32'h0000_0000);
         check("wrap_addr8", {16'd0, pop_addr[8]}, 32'h0000_000C);
      end

      // HALT while an enc frame is in flight: enc completes, then F800, then DONE
      rand_ready = 1'b1;
      issue_group(1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      cpu_halted = 1'b1;
      push_frame(3, 512'd0, 128'd0);
      wait_idle(1'b1, 500, "halt");
      repeat (2) tick();
      check("halt_done", {31'd0, done}, 32'd1);
      check("halt_busy", {31'd0, busy}, 32'd0);
      check("halt_wr_en", {31'd0, wr_en}, 32'd0);
      rand512(hash_result);
      hash_valid = 1'b1;
      wr_seen  = 0;
      ack_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         wr_seen  += int'(wr_en);
         ack_seen += int'(hash_ack) + int'(enc_ack) + int'(dec_ack);
      end
      check("done_no_wr_en", wr_seen, 32'd0);
      check("done_no_ack", ack_seen, 32'd0);
      check("done_sticky", {31'd0, done}, 32'd1);
      check("ack_total", got_acks, exp_acks);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
